// File: rtl/imem_fetch_responder_if.sv
// Fetch/load bus of the instruction-memory responder.
//
// Handshake rule for both channels: a transfer happens on the rising edge
// where valid && ready are both high. The initiator holds valid and payload
// stable until that edge; the responder holds resp_valid, resp_instr and
// resp_err stable until its response is taken.
//
// Signals:
//   req_valid/req_ready/req_addr        fetch request (byte PC)
//   resp_valid/resp_ready/resp_instr/
//   resp_err                            fetch response
//   load_en/load_addr/load_data         program-word write port (no handshake)
//   busy                                responder is in WAIT or RESP
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_err;
    logic        load_en;
    logic [63:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    modport master (
        output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_instr, resp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_instr, resp_err, busy
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: serves 32-bit fetches from a word array with a
// fixed LATENCY, flags misaligned / out-of-range PCs with a NOP response, and
// accepts program-word loads in any state.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; aborts any in-flight fetch
//   bus        imem_fetch_responder_if.slave (request, response, load, busy)
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module imem_fetch_responder #(
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                 clock,
    input  logic                 reset,
    imem_fetch_responder_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int AW = $clog2(DEPTH);
    // Counter only ever holds LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   addr_q;
    logic [31:0]   instr_q;
    logic          err_q;
    logic          accept;
    logic          capture;
    logic [63:0]   rd_addr;
    logic          rd_err;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem [DEPTH];

    // Full 62-bit index compare so high PC bits never alias into the array.
    function automatic logic addr_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a[63:2] >= 62'(DEPTH));
    endfunction

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = (state == RESP) && !reset;
    assign bus.resp_instr = instr_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state != IDLE);
    assign dbg_state      = state;

    assign accept = bus.req_valid && bus.req_ready;

    // With LATENCY==1 the response is captured on the accept edge itself,
    // before addr_q holds the new PC, so read straight from the request.
    assign rd_addr = (state == IDLE) ? bus.req_addr : addr_q;
    assign rd_idx  = rd_addr[AW+1:2];
    assign rd_err  = addr_bad(rd_addr);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        capture = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = RESP;
                    capture = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_valid && bus.resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= bus.req_addr;
            end
            // mem read here sees writes from earlier edges only; a load on
            // this same edge lands after the read.
            if (capture) begin
                err_q   <= rd_err;
                instr_q <= rd_err ? NOP_WORD : mem[rd_idx];
            end
        end
    end

    // Program store is never cleared and loads are taken in every state.
    always_ff @(posedge clock) begin
        if (bus.load_en && !addr_bad(bus.load_addr)) begin
            mem[bus.load_addr[AW+1:2]] <= bus.load_data;
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;
    localparam logic [31:0] NOP = 32'h00000013;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg0, dbg1;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    // {err, instr}
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] e0, e1;

    logic [63:0] a1 [4];
    logic [32:0] x1 [4];

    imem_fetch_responder_if b0 ();
    imem_fetch_responder_if b1 ();

    imem_fetch_responder #(.DEPTH(256), .LATENCY(2), .NOP_WORD(NOP)) u_dut0 (
        .clock(clock), .reset(reset), .bus(b0), .dbg_state(dbg0)
    );
    imem_fetch_responder #(.DEPTH(256), .LATENCY(1), .NOP_WORD(NOP)) u_dut1 (
        .clock(clock), .reset(reset), .bus(b1), .dbg_state(dbg1)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clock) begin
        if (b0.resp_valid) begin
            if (exp_q0.size() == 0) begin
                check("dut0_unexpected_resp", b0.resp_valid, 1'b0);
            end else if (b0.resp_ready) begin
                e0 = exp_q0.pop_front();
                check("dut0_instr", b0.resp_instr, e0[31:0]);
                check("dut0_err", b0.resp_err, e0[32]);
            end else begin
                check("dut0_hold_instr", b0.resp_instr, exp_q0[0][31:0]);
            end
        end
    end

    always @(negedge clock) begin
        if (b1.resp_valid) begin
            if (exp_q1.size() == 0) begin
                check("dut1_unexpected_resp", b1.resp_valid, 1'b0);
            end else if (b1.resp_ready) begin
                e1 = exp_q1.pop_front();
                check("dut1_instr", b1.resp_instr, e1[31:0]);
                check("dut1_err", b1.resp_err, e1[32]);
            end else begin
                check("dut1_hold_instr", b1.resp_instr, exp_q1[0][31:0]);
            end
        end
    end

    // ---------------- driver tasks (DUT0, LATENCY=2) ----------------
    task automatic load0(input logic [63:0] addr, input logic [31:0] data);
        b0.load_en   = 1'b1;
        b0.load_addr = addr;
        b0.load_data = data;
        @(posedge clock); #1;
        b0.load_en = 1'b0;
    endtask

    // ld_at: -1 no load, 0 load commits on the accept edge, 1 load commits
    // on the RESP-entry edge. Loads always target address 0x0.
    task automatic fetch0(input logic [63:0] addr, input logic [31:0] ex_instr,
                          input logic ex_err, input int hold, input int ld_at,
                          input logic [31:0] ld_data);
        int n;
        int lat;
        exp_q0.push_back({ex_err, ex_instr});
        b0.req_valid  = 1'b1;
        b0.req_addr   = addr;
        b0.resp_ready = (hold == 0);
        b0.load_addr  = 64'h0;
        b0.load_data  = ld_data;
        b0.load_en    = (ld_at == 0);
        n = 0;
        @(negedge clock);
        while (!b0.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("dut0_accept_ready", b0.req_ready, 1'b1);
        @(posedge clock); #1;
        b0.req_valid = 1'b0;
        b0.req_addr  = 64'h8;  // must be ignored after the accept edge
        b0.load_en   = (ld_at == 1);
        check("dut0_busy_after_accept", b0.busy, 1'b1);
        lat = 1;
        while (!b0.resp_valid && lat < 20) begin
            @(posedge clock); #1;
            b0.load_en = 1'b0;
            lat++;
        end
        b0.load_en = 1'b0;
        check("dut0_latency", lat, 2);
        repeat (hold) begin
            @(negedge clock);
            check("dut0_req_ready_in_resp", b0.req_ready, 1'b0);
            check("dut0_resp_valid_held", b0.resp_valid, 1'b1);
            @(posedge clock); #1;
        end
        b0.resp_ready = 1'b1;
        @(posedge clock); #1;
        check("dut0_resp_valid_after_hs", b0.resp_valid, 1'b0);
        check("dut0_req_ready_after_hs", b0.req_ready, 1'b1);
        check("dut0_busy_after_hs", b0.busy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int last_acc;
        b0.req_valid = 0; b0.req_addr = 0; b0.resp_ready = 1;
        b0.load_en = 0; b0.load_addr = 0; b0.load_data = 0;
        b1.req_valid = 0; b1.req_addr = 0; b1.resp_ready = 1;
        b1.load_en = 0; b1.load_addr = 0; b1.load_data = 0;

        repeat (2) @(posedge clock); #1;
        check("reset_req_ready", b0.req_ready, 1'b0);
        check("reset_resp_valid", b0.resp_valid, 1'b0);
        check("reset_busy", b0.busy, 1'b0);
        check("reset_resp_instr", b0.resp_instr, 32'h0);
        check("reset_resp_err", b0.resp_err, 1'b0);
        check("reset_state", dbg0, 2'd0);
        reset = 1'b0;

        // Program, then reset again: contents must survive.
        load0(64'h0, 32'h00500093);
        load0(64'h4, 32'h00A00113);
        load0(64'h3FC, 32'h12345678);
        reset = 1'b1;
        @(negedge clock);
        check("reset_cycle_req_ready", b0.req_ready, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_req_ready", b0.req_ready, 1'b1);
        @(posedge clock); #1;

        // Basic fetch and backpressure.
        fetch0(64'h4, 32'h00A00113, 1'b0, 0, -1, 32'h0);
        fetch0(64'h0, 32'h00500093, 1'b0, 5, -1, 32'h0);

        // Range / alignment boundaries.
        fetch0(64'h3FC, 32'h12345678, 1'b0, 0, -1, 32'h0);
        fetch0(64'h6, NOP, 1'b1, 0, -1, 32'h0);
        fetch0(64'h400, NOP, 1'b1, 0, -1, 32'h0);
        fetch0(64'h1_0000_0000, NOP, 1'b1, 0, -1, 32'h0);

        // Load visibility around the RESP-entry edge.
        fetch0(64'h0, 32'hDEADBEEF, 1'b0, 0, 0, 32'hDEADBEEF);
        load0(64'h0, 32'h00500093);
        fetch0(64'h0, 32'h00500093, 1'b0, 0, 1, 32'hDEADBEEF);
        fetch0(64'h0, 32'hDEADBEEF, 1'b0, 0, -1, 32'h0);

        // Bad loads are dropped.
        load0(64'h2, 32'hBAD0BAD0);
        load0(64'h400, 32'hBAD1BAD1);
        load0(64'h1_0000_0000, 32'hBAD2BAD2);
        fetch0(64'h0, 32'hDEADBEEF, 1'b0, 0, -1, 32'h0);

        // Reset during WAIT aborts the fetch.
        b0.req_valid = 1'b1;
        b0.req_addr  = 64'h4;
        @(negedge clock);
        check("abort_accept_ready", b0.req_ready, 1'b1);
        @(posedge clock); #1;
        b0.req_valid = 1'b0;
        check("abort_in_wait", dbg0, 2'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_req_ready", b0.req_ready, 1'b1);
        check("abort_state_idle", dbg0, 2'd0);
        repeat (6) begin
            @(negedge clock);
            check("abort_no_resp", b0.resp_valid, 1'b0);
        end
        @(posedge clock); #1;
        fetch0(64'h4, 32'h00A00113, 1'b0, 0, -1, 32'h0);

        // LATENCY=1 instance: back-to-back requests.
        b1.load_en = 1'b1; b1.load_addr = 64'h0; b1.load_data = 32'h00500093;
        @(posedge clock); #1;
        b1.load_addr = 64'h4; b1.load_data = 32'h00A00113;
        @(posedge clock); #1;
        b1.load_en = 1'b0;
        a1[0] = 64'h4; x1[0] = {1'b0, 32'h00A00113};
        a1[1] = 64'h0; x1[1] = {1'b0, 32'h00500093};
        a1[2] = 64'h2; x1[2] = {1'b1, NOP};
        a1[3] = 64'h4; x1[3] = {1'b0, 32'h00A00113};
        last_acc = 0;
        b1.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q1.push_back(x1[i]);
            b1.req_valid = 1'b1;
            b1.req_addr  = a1[i];
            n = 0;
            @(negedge clock);
            while (!b1.req_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("dut1_accept_ready", b1.req_ready, 1'b1);
            if (i > 0) check("dut1_spacing", cyc - last_acc, 2);
            last_acc = cyc;
            @(posedge clock); #1;
            check("dut1_latency", b1.resp_valid, 1'b1);
        end
        b1.req_valid = 1'b0;

        repeat (4) @(negedge clock);
        check("dut0_queue_empty", exp_q0.size(), 0);
        check("dut1_queue_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder. It serves 32-bit instruction fetch requests from the fetch stage over a valid/ready request/response handshake with fixed multi-cycle latency. A separate load port writes program words into the array before or during execution. It sits between the fetch stage (initiator) and the program store, and converts a byte PC into a word access with alignment and range checking.

Parameters:
DEPTH, 256, number of 32-bit instruction words held (power of two, >=2)
LATENCY, 2, cycles from request-accept edge to resp_valid high (>=1)
NOP_WORD, 32'h00000013, instruction returned on an error response (addi x0,x0,0)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request
req_addr  input  64  byte address (PC) of requested instruction
resp_valid  output  1  response present
resp_ready  input  1  fetch stage accepts response
resp_instr  output  32  fetched instruction word
resp_err  output  1  request was misaligned or out of range
load_en  input  1  write one program word this cycle
load_addr  input  64  byte address of program word
load_data  input  32  program word
busy  output  1  high in WAIT or RESP

Behaviour:
- Reset (sync, active-high): state=IDLE, req_ready=0 during the reset cycle and 1 from the first cycle after. resp_valid=0, resp_instr=0, resp_err=0, busy=0, latency counter=0. Array contents are NOT cleared.
- Reset asserted mid-transaction aborts it. No response is ever produced for the aborted request.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr and set counter=LATENCY-1. Go to RESP if LATENCY==1, else to WAIT.
  - WAIT: req_ready=0. Decrement counter each cycle. When counter reaches 1, go to RESP on the next edge.
  - RESP: resp_valid=1, req_ready=0. resp_instr and resp_err stay stable until resp_valid&&resp_ready. On that handshake go to IDLE: resp_valid=0, req_ready=1 next cycle.
  - Backpressure: RESP holds for any number of cycles.
- Latency:
  - resp_valid rises exactly LATENCY cycles after the accept edge.
  - Minimum request-to-request spacing is LATENCY+1 cycles with resp_ready tied high.
  - No new request is accepted in the cycle of the response handshake.
- Address decode: word index = addr[63:2].
  - Misaligned if addr[1:0]!=0.
  - Out of range if addr[63:2] >= DEPTH, evaluated on the full 62-bit index, with no wrap-around.
  - Either condition gives resp_err=1 and resp_instr=NOP_WORD.
  - Otherwise resp_err=0 and resp_instr=array[index].
- Data sampling: resp_instr/resp_err are registered on the edge entering RESP. They reflect every load committed on earlier edges. A load on that same edge is not visible to the response.
- Load port:
  - Accepted in any FSM state. Writes load_data to array[load_addr[63:2]] on the edge.
  - Ignored silently if load_addr is misaligned or out of range.
  - Loads never affect req_ready, resp_valid or an already registered response.
- req_addr is sampled only at the accept edge. Later changes are ignored.
- busy = (state != IDLE).

Test Plan:
- Load words 0x00500093 at 0x0 and 0x00A00113 at 0x4. Reset, then request 0x4 with resp_ready=1 and LATENCY=2 -> resp_valid high exactly 2 cycles after accept, resp_instr=0x00A00113, resp_err=0. req_ready high again the cycle after the handshake.
- Request 0x0 and hold resp_ready=0 for 5 cycles -> resp_valid stays 1 and resp_instr=0x00500093 stays stable. req_ready=0 throughout. Single handshake, then IDLE.
- Request 0x6, then request 0x400 (index 256 with DEPTH=256) -> both give resp_err=1 and resp_instr=0x00000013.
- Request 0x0 while loading 0xDEADBEEF to 0x0 during WAIT, one cycle before RESP -> resp_instr=0xDEADBEEF. Repeat with the load on the RESP-entry edge -> old word returned; the next fetch returns 0xDEADBEEF.
- Assert reset during WAIT -> resp_valid never asserts for that request. req_ready=1 the cycle after reset drops. Array contents are preserved (refetch 0x4 returns 0x00A00113).
- With LATENCY=1, issue back-to-back requests with resp_ready=1 -> accepts every 2 cycles, resp_valid exactly 1 cycle after each accept.
